// File: rtl/panel_rx.sv
// panel_rx: LED panel scan receiver.
// Rebuilds latched scanlines and streams them as tagged pixels.
module panel_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        p_clk,
  input  logic        p_lat,
  input  logic        p_oe_n,
  input  logic [5:0]  p_rgb,
  input  logic [2:0]  p_abc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_rgb,
  output logic [5:0]  out_col,
  output logic [2:0]  out_line,
  output logic        out_last,
  output logic [15:0] out_on_cycles,
  output logic        err_count,
  output logic        err_drop
);

  localparam int W = 12;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] s;
  logic         s_clk, s_lat, s_oe_n;
  logic [5:0]   s_rgb;
  logic [2:0]   s_abc;
  logic         clk_q, lat_q;
  logic         shift_ev, lat_ev, xfer;

  logic [5:0]   sr      [64];
  logic [5:0]   sr_next [64];
  logic [5:0]   row     [64];
  logic [6:0]   cnt, cnt_next;
  logic [15:0]  on_cnt, on_next;
  state_t       state, state_d;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      clk_q <= 1'b0;
      lat_q <= 1'b0;
    end else begin
      sync_q[0] <= {p_clk, p_lat, p_oe_n, p_rgb, p_abc};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      clk_q <= s_clk;
      lat_q <= s_lat;
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign s_clk    = s[11];
  assign s_lat    = s[10];
  assign s_oe_n   = s[9];
  assign s_rgb    = s[8:3];
  assign s_abc    = s[2:0];
  assign shift_ev = s_clk & ~clk_q;
  assign lat_ev   = s_lat & ~lat_q;

  // Newest pixel enters at column 63 so the first one ends at column 0.
  always_comb begin
    for (int k = 0; k < 63; k++)
      sr_next[k] = shift_ev ? sr[k+1] : sr[k];
    sr_next[63] = shift_ev ? s_rgb : sr[63];
  end

  assign cnt_next = (shift_ev && cnt != 7'd127) ? cnt + 7'd1 : cnt;
  assign on_next  = (!s_oe_n && on_cnt != 16'hFFFF) ? on_cnt + 16'd1
                                                    : on_cnt;

  assign out_valid = (state == STREAM);
  assign out_rgb   = row[out_col];
  assign out_last  = out_valid && (out_col == 6'd63);
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:   if (lat_ev) state_d = STREAM;
      STREAM: if (xfer && out_col == 6'd63) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int k = 0; k < 64; k++) begin
        sr[k]  <= '0;
        row[k] <= '0;
      end
      cnt           <= '0;
      on_cnt        <= '0;
      out_col       <= '0;
      out_line      <= '0;
      out_on_cycles <= '0;
      err_count     <= 1'b0;
      err_drop      <= 1'b0;
    end else begin
      sr     <= sr_next;
      cnt    <= lat_ev ? 7'd0 : cnt_next;
      on_cnt <= lat_ev ? 16'd0 : on_next;
      if (xfer)
        out_col <= out_col + 6'd1;
      if (lat_ev) begin
        if (cnt_next != 7'd64)
          err_count <= 1'b1;
        if (state == IDLE) begin
          row           <= sr_next;
          out_line      <= s_abc;
          out_on_cycles <= on_next;
        end else begin
          err_drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_panel_rx.sv
// tb_panel_rx: randomized scenarios for panel_rx.
// Reference keeps every shifted pixel; a latched row is the newest 64.
module tb_panel_rx;

  localparam int SS = 2;

  logic        clk_in = 0;
  logic        reset = 0;
  logic        p_clk = 0;
  logic        p_lat = 0;
  logic        p_oe_n = 1;
  logic [5:0]  p_rgb = 0;
  logic [2:0]  p_abc = 0;
  logic        out_ready = 0;
  logic        out_valid;
  logic [5:0]  out_rgb;
  logic [5:0]  out_col;
  logic [2:0]  out_line;
  logic        out_last;
  logic [15:0] out_on_cycles;
  logic        err_count;
  logic        err_drop;

  panel_rx #(.SYNC_STAGES(SS)) dut (
    .clk_in(clk_in), .reset(reset),
    .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n),
    .p_rgb(p_rgb), .p_abc(p_abc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rgb(out_rgb), .out_col(out_col),
    .out_line(out_line), .out_last(out_last),
    .out_on_cycles(out_on_cycles),
    .err_count(err_count), .err_drop(err_drop)
  );

  always #5 clk_in = ~clk_in;

  int vecs = 0;
  int errs = 0;

  logic [5:0]  hist [$];
  int          nshift;
  bit          busy;
  logic [5:0]  exp_row [64];
  logic [2:0]  exp_line;
  bit          exp_ec, exp_ed;
  int          oe_low;
  bit          oe_valid;
  logic [15:0] exp_on;
  bit          on_known;

  logic [5:0]  cap_rgb [64];
  logic [5:0]  cap_col [64];
  logic [2:0]  cap_line [64];
  logic        cap_last [64];
  int          ncap, nunstable;
  logic        post_valid;

  function automatic void model_reset();
    hist = {};
    for (int i = 0; i < 64; i++) begin
      hist.push_back(6'd0);
      exp_row[i] = 6'd0;
    end
    nshift = 0;
    busy = 0;
    exp_line = 0;
    exp_ec = 0;
    exp_ed = 0;
    oe_low = 0;
    oe_valid = 0;
    on_known = 0;
    exp_on = 0;
  endfunction

  function automatic void model_latch();
    if (nshift != 64) exp_ec = 1;
    if (busy) begin
      exp_ed = 1;
    end else begin
      for (int k = 0; k < 64; k++)
        exp_row[k] = hist[hist.size() - 64 + k];
      exp_line = p_abc;
      exp_on = (oe_low > 65535) ? 16'hFFFF : 16'(oe_low);
      on_known = oe_valid;
      busy = 1;
    end
    nshift = 0;
    oe_low = 0;
    oe_valid = 1;
  endfunction

  task automatic do_reset();
    @(posedge clk_in); #1 reset = 1;
    repeat (2) @(posedge clk_in);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic shift_px(input logic [5:0] v, input bit with_lat);
    @(posedge clk_in); #1 p_rgb = v;
    repeat (2) @(posedge clk_in);
    #1 p_clk = 1;
    p_lat = with_lat;
    hist.push_back(v);
    if (nshift < 127) nshift++;
    repeat (2) @(posedge clk_in);
    #1 p_clk = 0;
    p_lat = 0;
    if (with_lat) model_latch();
  endtask

  task automatic latch_only();
    @(posedge clk_in); #1 p_lat = 1;
    repeat (2) @(posedge clk_in);
    #1 p_lat = 0;
    model_latch();
  endtask

  task automatic send_line(input int n, input logic [2:0] abc,
                           input bit seq, input bit lat_last);
    logic [5:0] v;
    p_abc = abc;
    for (int i = 0; i < n; i++) begin
      v = seq ? 6'(i) : 6'($urandom);
      shift_px(v, lat_last && i == n - 1);
    end
    if (!lat_last) latch_only();
    repeat (8) @(posedge clk_in);
  endtask

  task automatic collect(input bit bp);
    int cyc;
    bit held;
    logic [16:0] hv;
    cyc = 0;
    held = 0;
    hv = '0;
    ncap = 0;
    nunstable = 0;
    while (ncap < 64 && cyc < 1000) begin
      @(negedge clk_in);
      cyc++;
      if (held && {out_valid, out_rgb, out_col, out_line, out_last} !== hv)
        nunstable++;
      out_ready = bp ? (cyc % 4 == 1 || cyc % 4 == 0) : 1'b1;
      held = 0;
      if (out_valid) begin
        if (out_ready) begin
          cap_rgb[ncap] = out_rgb;
          cap_col[ncap] = out_col;
          cap_line[ncap] = out_line;
          cap_last[ncap] = out_last;
          ncap++;
        end else begin
          held = 1;
          hv = {1'b1, out_rgb, out_col, out_line, out_last};
        end
      end
    end
    @(posedge clk_in); #1 out_ready = 0;
    @(negedge clk_in);
    post_valid = out_valid;
    busy = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_in);
    vecs++;
    if ({out_valid, out_col, out_line, out_rgb, out_last, out_on_cycles,
         err_count, err_drop} !== '0)
      begin
        errs++;
        $display("FAIL reset: got valid=%b col=%0d line=%0d rgb=%h last=%b on=%0d ec=%b ed=%b, expected all 0",
                 out_valid, out_col, out_line, out_rgb, out_last,
                 out_on_cycles, err_count, err_drop);
      end
  endtask

  task automatic test_basic();
    send_line(64, 3'd5, 1, 0);
    collect(0);
    vecs++;
    if (ncap !== 64 || post_valid !== 1'b0) begin
      errs++;
      $display("FAIL basic beats: got %0d valid_after=%b, expected 64 and 0",
               ncap, post_valid);
    end
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if ({cap_col[k], cap_rgb[k], cap_line[k], cap_last[k]} !==
          {6'(k), exp_row[k], exp_line, k == 63}) begin
        errs++;
        $display("FAIL basic beat %0d: got col=%0d rgb=%h line=%0d last=%b, expected col=%0d rgb=%h line=%0d last=%b",
                 k, cap_col[k], cap_rgb[k], cap_line[k], cap_last[k],
                 k, exp_row[k], exp_line, k == 63);
      end
    end
    vecs++;
    if ({err_count, err_drop} !== {exp_ec, exp_ed}) begin
      errs++;
      $display("FAIL basic flags: got ec=%b ed=%b, expected ec=%b ed=%b",
               err_count, err_drop, exp_ec, exp_ed);
    end
  endtask

  task automatic test_backpressure();
    send_line(64, 3'($urandom), 0, 0);
    collect(1);
    vecs++;
    if (ncap !== 64 || nunstable !== 0) begin
      errs++;
      $display("FAIL bp beats: got %0d beats %0d unstable, expected 64 and 0",
               ncap, nunstable);
    end
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if ({cap_col[k], cap_rgb[k], cap_line[k], cap_last[k]} !==
          {6'(k), exp_row[k], exp_line, k == 63}) begin
        errs++;
        $display("FAIL bp beat %0d: got col=%0d rgb=%h line=%0d, expected col=%0d rgb=%h line=%0d",
                 k, cap_col[k], cap_rgb[k], cap_line[k],
                 k, exp_row[k], exp_line);
      end
    end
    vecs++;
    if (on_known && out_on_cycles !== exp_on) begin
      errs++;
      $display("FAIL bp on_cycles: got %0d, expected %0d",
               out_on_cycles, exp_on);
    end
  endtask

  task automatic test_short_line();
    send_line(63, 3'($urandom), 0, 0);
    collect(0);
    vecs++;
    if (ncap !== 64 || err_count !== 1'b1) begin
      errs++;
      $display("FAIL short: got %0d beats ec=%b, expected 64 beats ec=1",
               ncap, err_count);
    end
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if ({cap_col[k], cap_rgb[k]} !== {6'(k), exp_row[k]}) begin
        errs++;
        $display("FAIL short beat %0d: got col=%0d rgb=%h, expected col=%0d rgb=%h",
                 k, cap_col[k], cap_rgb[k], k, exp_row[k]);
      end
    end
    do_reset();
    @(negedge clk_in);
    vecs++;
    if (err_count !== 1'b0) begin
      errs++;
      $display("FAIL short clear: got ec=%b, expected 0", err_count);
    end
  endtask

  task automatic test_overrun();
    send_line(70, 3'd2, 1, 0);
    collect(0);
    vecs++;
    if (ncap !== 64 || err_count !== 1'b1) begin
      errs++;
      $display("FAIL overrun: got %0d beats ec=%b, expected 64 beats ec=1",
               ncap, err_count);
    end
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if (cap_rgb[k] !== exp_row[k] || cap_rgb[k] !== 6'(k + 6)) begin
        errs++;
        $display("FAIL overrun beat %0d: got rgb=%0d, expected %0d",
                 k, cap_rgb[k], k + 6);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    send_line(64, 3'd1, 0, 0);
    send_line(64, 3'd6, 0, 0);
    vecs++;
    if (err_drop !== 1'b1 || exp_ed !== 1'b1 || out_valid !== 1'b1) begin
      errs++;
      $display("FAIL drop flag: got ed=%b valid=%b, expected ed=1 valid=1",
               err_drop, out_valid);
    end
    collect(0);
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if ({cap_rgb[k], cap_line[k]} !== {exp_row[k], 3'd1}) begin
        errs++;
        $display("FAIL drop beat %0d: got rgb=%h line=%0d, expected rgb=%h line=1",
                 k, cap_rgb[k], cap_line[k], exp_row[k]);
      end
    end
    vecs++;
    if ({ncap == 64, err_count, err_drop} !== {1'b1, exp_ec, exp_ed}) begin
      errs++;
      $display("FAIL drop end: got %0d beats ec=%b ed=%b, expected 64 ec=%b ed=%b",
               ncap, err_count, err_drop, exp_ec, exp_ed);
    end
  endtask

  task automatic test_simultaneous_oe();
    logic [5:0] v;
    do_reset();
    send_line(64, 3'd3, 0, 0);
    collect(0);
    p_abc = 3'd6;
    for (int i = 0; i < 63; i++)
      shift_px(6'($urandom), 0);
    @(posedge clk_in); #1 p_oe_n = 0;
    repeat (100) @(posedge clk_in);
    #1 p_oe_n = 1;
    oe_low += 100;
    v = 6'($urandom);
    shift_px(v, 1);
    repeat (8) @(posedge clk_in);
    collect(0);
    vecs++;
    if ({err_count, out_on_cycles} !== {1'b0, 16'd100} || !on_known ||
        exp_on !== 16'd100) begin
      errs++;
      $display("FAIL simul: got ec=%b on=%0d, expected ec=0 on=100",
               err_count, out_on_cycles);
    end
    vecs++;
    if (ncap !== 64 || cap_rgb[63] !== v || exp_row[63] !== v) begin
      errs++;
      $display("FAIL simul col63: got %0d beats rgb=%h, expected 64 rgb=%h",
               ncap, cap_rgb[63], v);
    end
    for (int k = 0; k < ncap; k++) begin
      vecs++;
      if ({cap_rgb[k], cap_line[k]} !== {exp_row[k], 3'd6}) begin
        errs++;
        $display("FAIL simul beat %0d: got rgb=%h line=%0d, expected rgb=%h line=6",
                 k, cap_rgb[k], cap_line[k], exp_row[k]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int cyc;
    send_line(64, 3'($urandom), 0, 0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(negedge clk_in);
      cyc++;
    end
    out_ready = 1;
    repeat (5) @(negedge clk_in);
    reset = 1;
    out_ready = 0;
    @(negedge clk_in);
    vecs++;
    if ({out_valid, out_col, err_count, err_drop} !== '0) begin
      errs++;
      $display("FAIL midreset: got valid=%b col=%0d ec=%b ed=%b, expected all 0",
               out_valid, out_col, err_count, err_drop);
    end
    reset = 0;
    model_reset();
    repeat (4) @(negedge clk_in);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_backpressure();
    test_short_line();
    test_overrun();
    test_drop();
    test_simultaneous_oe();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/panel_rx.md
# panel_rx

Receiver for the LED panel scan interface: it samples the panel signals (CLK, LAT, OE/, RGB01, ABC) on the system clock and rebuilds each 64-pixel logical scanline exactly as the panel's shift registers would hold it. On every latch it hands the line to a valid/ready pixel stream tagged with line and column. It sits on the consumer side of the panel timing generator and serves as a bench monitor, a loopback checker, or a panel emulator front end.

## Interface
- `SYNC_STAGES`, default 2: input synchronizer depth applied to all panel inputs; legal values are 2 or 3.
- `clk_in` input, 1 bit: system clock. It must be at least 4x the panel CLK rate.
- `reset` input, 1 bit: synchronous, active-high.
- `p_clk` input, 1 bit: panel shift clock. Data is captured on its rising edge.
- `p_lat` input, 1 bit: panel latch. It acts on its rising edge.
- `p_oe_n` input, 1 bit: panel output enable, active low.
- `p_rgb` input, 6 bits: `{b1,g1,r1,b0,g0,r0}` serial pixel data.
- `p_abc` input, 3 bits: scanline select.
- `out_valid` output, 1 bit: pixel available.
- `out_ready` input, 1 bit: consumer accepts the pixel.
- `out_rgb` output, 6 bits: pixel data.
- `out_col` output, 6 bits: column index, 0..63.
- `out_line` output, 3 bits: `p_abc` value captured at the latch.
- `out_last` output, 1 bit: high together with `out_col == 63`.
- `out_on_cycles` output, 16 bits: `clk_in` cycles with `p_oe_n` low between the previous latch and this latch, saturating.
- `err_count` output, 1 bit: sticky. Set when a latch occurs with a shift count other than 64.
- `err_drop` output, 1 bit: sticky. Set when a latch occurs while the output stream is busy.

## Operation
- **Input synchronization.**
  - All `p_*` inputs pass through a `SYNC_STAGES` flop chain.
  - One further register provides the previous value, used for rising-edge detect of `p_clk` and `p_lat`.
  - Data inputs are delayed by the same depth, so `p_rgb` and `p_abc` stay aligned with the `p_clk` edge.
- **Shift register.**
  - 64 x 6 bits. On each detected `p_clk` rise, `p_rgb` is shifted in.
  - Column mapping: the pixel shifted first since the last latch is column 0. After exactly 64 shifts, column k holds the (k+1)-th shifted pixel.
  - Shifting continues beyond 64. The oldest entries fall off, so the last 64 shifts are retained.
- **Shift counter.**
  - 7 bits, saturating at 127, cleared on every detected latch.
  - If a `p_clk` rise and a `p_lat` rise are detected in the same cycle, the shift happens first and the latch includes the new pixel; the count also includes it.
- **On-time counter.**
  - 16 bits, saturating at 0xFFFF.
  - Increments each cycle the synchronized `p_oe_n` is 0.
  - On a latch its value (including the latch cycle) is transferred to the `out_on_cycles` holding register, and the counter clears.
- **Latch handling**, by FSM state when the latch is detected:
  - In IDLE: copy the shift register into the row buffer; capture `p_abc` into `out_line`; capture the on-time value; set `err_count` if the shift count is not 64; go to STREAM.
  - In STREAM: the row buffer, `out_line` and `out_on_cycles` are unchanged; set `err_drop`. The shift counter and on-time counter still clear. `err_count` is still evaluated.
- **FSM, two states.**
  - IDLE: `out_valid` = 0.
  - STREAM: `out_valid` = 1. `out_col` is the read pointer and `out_rgb` = `row[out_col]`.
  - A transfer occurs when `out_valid` and `out_ready` are both high; the pointer then advances.
  - A transfer with `out_col == 63` returns the FSM to IDLE and resets the pointer to 0.
- **Handshake rules.** While `out_valid` is high and `out_ready` is low, `out_rgb`, `out_col`, `out_line` and `out_last` are held stable. `out_valid` never drops without a transfer.
- **Reset.** In-flight stream and shift contents are discarded.
  - Outputs: `out_valid`=0, `out_col`=0, `out_line`=0, `out_rgb`=0, `out_last`=0, `out_on_cycles`=0, `err_count`=0, `err_drop`=0.
  - Internal state: FSM=IDLE, shift register=0, counters=0, synchronizers=0.

## Timing
- An input edge appears in the synchronizer output after `SYNC_STAGES` clocks. The edge-detect strobe is valid on the next cycle, and the register update (shift or latch) lands at the end of that cycle: `SYNC_STAGES`+1 `clk_in` cycles after the input change.
- The first `out_valid` = 1 appears one cycle after the latch update.
- The minimum line stream takes 64 cycles with `out_ready` held high. The FSM is back in IDLE on the cycle after the col-63 transfer, so a latch detected in that cycle is accepted.
- Minimum pulse width requirements:
  - `p_clk` must be high for at least 2 and low for at least 2 `clk_in` cycles.
  - `p_lat` must be high for at least 2 cycles.
  - `p_rgb` and `p_abc` must be stable from 1 cycle before to 1 cycle after the `p_clk` rise.
  - Behaviour is undefined outside these limits.

## Test plan
- **Basic line:** 64 shifts with `p_rgb` = column index mod 64 (low 6 bits), `p_abc`=5, then a latch; `out_ready`=1 → 64 beats, col k carries rgb k, `out_line`=5, `out_last` only on col 63, no errors.
- **Back-pressure:** same line with `out_ready` toggling 1-0-0-1 → every column is delivered exactly once, in order, with data held stable while stalled.
- **Short line:** 63 shifts, then latch → `err_count`=1; 64 beats are still streamed. Reset → `err_count`=0.
- **Overrun:** 70 shifts with values 0..69, then latch → `err_count`=1 and cols 0..63 carry values 6..69.
- **Drop:** second latch while streaming with `out_ready`=0 → `err_drop`=1; the stream completes with the first line's data and `out_line`.
- **Simultaneous edges and OE:** final `p_clk` rise coincident with the `p_lat` rise, with `p_oe_n` low for 100 cycles → no `err_count` (count=64), col 63 holds the last pixel, `out_on_cycles`=100. Reset mid-stream → `out_valid`=0 on the next cycle.
